mmu_sched: RTL and testbench
============================

Name: mmu_sched

Overview:
- Top-level tile scheduler for the systolic matrix-multiply unit.
- Accepts one command describing a run of N tiles.
- Per tile, sequences three steps in order: weight-load controller, then data read controller, then waits for the write-output controller to finish.
- Sits between the host/instruction decoder and the rd/wr/weight control blocks; owns all base-address bookkeeping.

Parameters:
- WIDTH_HEIGHT, 16, systolic array dimension; address step per tile.
- ADDR_WIDTH, 8, width of every base address.
- TILE_W, 8, width of the tile-count field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_num_tiles  in  TILE_W  tiles in this run.
- cmd_wt_base  in  ADDR_WIDTH  first weight base address.
- cmd_rd_base  in  ADDR_WIDTH  first input-data base address.
- cmd_wr_base  in  ADDR_WIDTH  first output base address.
- wt_active  out  1  1-cycle start pulse to the weight-load controller.
- wt_addr  out  ADDR_WIDTH  weight base for the current tile.
- wt_done  in  1  weight load complete (1-cycle pulse).
- rd_active  out  1  1-cycle start pulse to the read controller.
- rd_base  out  ADDR_WIDTH  data base for the current tile.
- wr_base  out  ADDR_WIDTH  output base for the current tile.
- wr_done  in  1  output write complete (1-cycle pulse).
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse at end of run.
- tile_idx  out  TILE_W  index of the current tile.

Behaviour:
- Clocking/reset: clk is the only clock; reset is asynchronous and active-high.
- Reset values: all outputs 0 except cmd_ready=1; state IDLE; all registers 0.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.

FSM states: IDLE, LOAD_W, WAIT_W, RUN, WAIT_WR, NEXT, FIN.
- IDLE: cmd_ready=1. On cmd_valid, latch the command.
  - num_tiles==0: go to FIN (no-op run; only done pulses).
  - Otherwise: go to LOAD_W with tile_idx=0 and the bases loaded.
- LOAD_W: wt_active=1 for exactly one cycle; then WAIT_W.
- WAIT_W: hold until wt_done; then RUN.
- RUN: rd_active=1 for one cycle; then WAIT_WR.
- WAIT_WR: hold until wr_done; then NEXT.
- NEXT:
  - Last tile (tile_idx==num_tiles-1): go to FIN.
  - Otherwise: tile_idx+1; wt_addr, rd_base and wr_base each += WIDTH_HEIGHT; go to LOAD_W.
- FIN: done=1 for one cycle; return to IDLE. cmd_ready rises the cycle after done.

Latency (command handshake at cycle 0):
- wt_active at cycle 1.
- wt_done at cycle k gives rd_active at k+2.
- wr_done at cycle m gives the next wt_active at m+2, or done at m+2.

Boundary conditions:
- Address arithmetic is modulo 2^ADDR_WIDTH; it silently wraps.
- wt_done or wr_done arriving outside its wait state is ignored and is not remembered.
- wt_done and wr_done asserted together: only the one matching the current wait state counts.
- cmd_valid while busy: not accepted; cmd_ready=0 and the command fields are ignored.
- Reset mid-run: immediate return to IDLE; no done pulse.
- num_tiles = 2^TILE_W-1 is legal.

Optional Feature:
- Macro: MMU_SCHED_WATCHDOG_EN.
- Compiled in:
  - Adds output timeout (1 bit, sticky) and parameter WDOG_CYCLES (default 1023).
  - A counter runs in WAIT_W and WAIT_WR and clears on every state change.
  - On reaching WDOG_CYCLES: timeout=1, FSM goes to FIN (done pulses). timeout clears on the next accepted command or on reset.
- Compiled out: no timeout port; the FSM waits indefinitely.

Decomposition:
- Shared package mmu_pkg holds:
  - State encoding localparams (3-bit): IDLE=0 … FIN=6.
  - Default WIDTH_HEIGHT and ADDR_WIDTH constants, shared with the rd/wr/weight controllers.
- One sub-module, mmu_addr_gen: three base registers with load and step (+WIDTH_HEIGHT) controls.
- FSM and tile counter stay in mmu_sched.

Test Plan:
- Single tile: num_tiles=1, wt=0x10, rd=0x20, wr=0x30; wt_done 5 cycles after wt_active; wr_done 40 cycles after rd_active.
  - Expect wt_addr=0x10, rd_base=0x20, wr_base=0x30.
  - Expect exactly one wt_active, one rd_active and one done pulse; busy low after done.
- Three tiles: wt=0, rd=0x40, wr=0x80.
  - Expect wt_addr 0, 16, 32; rd_base 0x40, 0x50, 0x60; wr_base 0x80, 0x90, 0xA0.
  - Expect done once, two cycles after the third wr_done.
- Zero tiles: num_tiles=0 → no wt_active or rd_active; done one cycle after the handshake; cmd_ready back high the following cycle.
- Wrap: rd_base=0xF8, 2 tiles → second tile rd_base=0x08.
- Spurious inputs and reset:
  - wr_done during WAIT_W → ignored; FSM stays in WAIT_W.
  - reset asserted in WAIT_WR → all outputs at reset values asynchronously; no done pulse.
  - A new command is accepted afterwards.
- Watchdog (MMU_SCHED_WATCHDOG_EN, WDOG_CYCLES=20): wt_done never arrives → timeout=1 and a done pulse 20 cycles after entering WAIT_W; the next command clears timeout.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the matrix-multiply control blocks: state encoding
// and default array geometry used by the scheduler and the rd/wr/weight controllers.
package mmu_pkg;

    localparam int MMU_WIDTH_HEIGHT = 16;
    localparam int MMU_ADDR_WIDTH   = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_W  = 3'd1;
    localparam logic [2:0] ST_WAIT_W  = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_WAIT_WR = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_FIN     = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD_W  = ST_LOAD_W,
        WAIT_W  = ST_WAIT_W,
        RUN     = ST_RUN,
        WAIT_WR = ST_WAIT_WR,
        NEXT    = ST_NEXT,
        FIN     = ST_FIN
    } sched_state_t;

endpackage

// File: rtl/mmu_addr_gen.sv
// Weight / input-data / output base-address registers: loaded from a command,
// advanced by one array height per tile, wrapping modulo 2^ADDR_WIDTH.
module mmu_addr_gen
    import mmu_pkg::*;
#(
    parameter int WIDTH_HEIGHT = MMU_WIDTH_HEIGHT,
    parameter int ADDR_WIDTH   = MMU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] wt_init,
    input  logic [ADDR_WIDTH-1:0] rd_init,
    input  logic [ADDR_WIDTH-1:0] wr_init,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic [ADDR_WIDTH-1:0] wr_base
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WIDTH_HEIGHT);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wt_addr <= '0;
            rd_base <= '0;
            wr_base <= '0;
        end else if (load) begin
            wt_addr <= wt_init;
            rd_base <= rd_init;
            wr_base <= wr_init;
        end else if (step) begin
            wt_addr <= wt_addr + STEP;
            rd_base <= rd_base + STEP;
            wr_base <= wr_base + STEP;
        end
    end

endmodule

// File: rtl/mmu_sched.sv
// Tile scheduler for the systolic matrix-multiply unit: runs N tiles of
// weight-load / read / write-wait. Optional watchdog: MMU_SCHED_WATCHDOG_EN.
module mmu_sched
    import mmu_pkg::*;
#(
    parameter int WIDTH_HEIGHT = MMU_WIDTH_HEIGHT,
    parameter int ADDR_WIDTH   = MMU_ADDR_WIDTH,
    parameter int TILE_W       = 8
`ifdef MMU_SCHED_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES  = 1023
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TILE_W-1:0]     cmd_num_tiles,
    input  logic [ADDR_WIDTH-1:0] cmd_wt_base,
    input  logic [ADDR_WIDTH-1:0] cmd_rd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_wr_base,
    output logic                  wt_active,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    input  logic                  wt_done,
    output logic                  rd_active,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic [ADDR_WIDTH-1:0] wr_base,
    input  logic                  wr_done,
    output logic                  busy,
    output logic                  done,
    output logic [TILE_W-1:0]     tile_idx
`ifdef MMU_SCHED_WATCHDOG_EN
    ,
    output logic                  timeout
`endif
);

    sched_state_t      state, next_state;
    logic [TILE_W-1:0] num_tiles;
    logic              accept, step, wdog_hit, last_tile;

    assign last_tile = (tile_idx == num_tiles - TILE_W'(1));

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = (cmd_num_tiles == '0) ? FIN : LOAD_W;
                end
            end
            LOAD_W:  next_state = WAIT_W;
            WAIT_W: begin
                if (wt_done)       next_state = RUN;
                else if (wdog_hit) next_state = FIN;
            end
            RUN:     next_state = WAIT_WR;
            WAIT_WR: begin
                if (wr_done)       next_state = NEXT;
                else if (wdog_hit) next_state = FIN;
            end
            NEXT: begin
                if (last_tile) begin
                    next_state = FIN;
                end else begin
                    step       = 1'b1;
                    next_state = LOAD_W;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pulses are registered from next_state so they line up with state entry;
    // the read start alone comes from RUN itself, one cycle after entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            wt_active <= 1'b0;
            rd_active <= 1'b0;
            done      <= 1'b0;
            num_tiles <= '0;
            tile_idx  <= '0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == IDLE);
            busy      <= (next_state != IDLE);
            wt_active <= (next_state == LOAD_W);
            rd_active <= (state == RUN);
            done      <= (next_state == FIN);
            if (accept) begin
                num_tiles <= cmd_num_tiles;
                tile_idx  <= '0;
            end else if (step) begin
                tile_idx  <= tile_idx + TILE_W'(1);
            end
        end
    end

`ifdef MMU_SCHED_WATCHDOG_EN
    logic [31:0] wdog_cnt;

    assign wdog_hit = (state == WAIT_W || state == WAIT_WR) &&
                      (wdog_cnt == 32'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (next_state != state)
                wdog_cnt <= '0;
            else if (state == WAIT_W || state == WAIT_WR)
                wdog_cnt <= wdog_cnt + 32'd1;
            if (accept)
                timeout <= 1'b0;
            else if (wdog_hit)
                timeout <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    mmu_addr_gen #(
        .WIDTH_HEIGHT (WIDTH_HEIGHT),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (step),
        .wt_init (cmd_wt_base),
        .rd_init (cmd_rd_base),
        .wr_init (cmd_wr_base),
        .wt_addr (wt_addr),
        .rd_base (rd_base),
        .wr_base (wr_base)
    );

endmodule

// File: tb/tb_mmu_sched.sv
// Self-checking bench for mmu_sched: the bench plays the weight/read/write
// controllers and predicts every pulse and address from the tile arithmetic.
module tb_mmu_sched;

    localparam int WH = 16;
    localparam int AW = 8;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_num_tiles;
    logic [AW-1:0] cmd_wt_base, cmd_rd_base, cmd_wr_base;
    logic          wt_active, rd_active, wt_done, wr_done;
    logic [AW-1:0] wt_addr, rd_base, wr_base;
    logic          busy, done;
    logic [TW-1:0] tile_idx;
`ifdef MMU_SCHED_WATCHDOG_EN
    logic          timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cnt_wt = 0, cnt_rd = 0, cnt_done = 0;

    always #5 clk = ~clk;

    mmu_sched #(
        .WIDTH_HEIGHT (WH),
        .ADDR_WIDTH   (AW),
        .TILE_W       (TW)
`ifdef MMU_SCHED_WATCHDOG_EN
        ,
        .WDOG_CYCLES  (20)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_num_tiles (cmd_num_tiles),
        .cmd_wt_base   (cmd_wt_base),
        .cmd_rd_base   (cmd_rd_base),
        .cmd_wr_base   (cmd_wr_base),
        .wt_active     (wt_active),
        .wt_addr       (wt_addr),
        .wt_done       (wt_done),
        .rd_active     (rd_active),
        .rd_base       (rd_base),
        .wr_base       (wr_base),
        .wr_done       (wr_done),
        .busy          (busy),
        .done          (done),
        .tile_idx      (tile_idx)
`ifdef MMU_SCHED_WATCHDOG_EN
        ,
        .timeout       (timeout)
`endif
    );

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (wt_active) cnt_wt++;
        if (rd_active) cnt_rd++;
        if (done)      cnt_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected base for tile i: linear step per tile, modulo 2^AW
    function automatic logic [AW-1:0] tile_addr(input logic [AW-1:0] base, input int i);
        return AW'((int'(base) + WH * i) % (1 << AW));
    endfunction

    task automatic wait_ready();
        for (int t = 0; t < 20 && !cmd_ready; t++) tick();
        check("cmd_ready_before_cmd", cmd_ready, 1);
    endtask

    // One full command; dw/dr = wait before wt_done / wr_done (0 = random),
    // spur = inject the other done signal and a garbage held command.
    task automatic run_cmd(input int n, input logic [AW-1:0] wt, input logic [AW-1:0] rd,
                           input logic [AW-1:0] wr, input int dw, input int dr, input bit spur);
        int w0, r0, d0, d;
        wait_ready();
        w0 = cnt_wt; r0 = cnt_rd; d0 = cnt_done;
        cmd_valid = 1'b1; cmd_num_tiles = TW'(n);
        cmd_wt_base = wt; cmd_rd_base = rd; cmd_wr_base = wr;
        tick();
        cmd_valid = spur && (n != 0);
        cmd_num_tiles = TW'($urandom_range(1, 255));
        cmd_wt_base = AW'($urandom); cmd_rd_base = AW'($urandom); cmd_wr_base = AW'($urandom);
        if (n == 0) begin
            check("zero_done", done, 1);
            check("zero_wt_active", wt_active, 0);
            check("zero_cmd_ready", cmd_ready, 0);
        end
        for (int i = 0; i < n; i++) begin
            check("wt_active", wt_active, 1);
            check("wt_addr", wt_addr, tile_addr(wt, i));
            check("rd_base", rd_base, tile_addr(rd, i));
            check("wr_base", wr_base, tile_addr(wr, i));
            check("tile_idx", tile_idx, i);
            check("busy_run", busy, 1);
            check("cmd_ready_run", cmd_ready, 0);
            d = (dw != 0) ? dw : int'($urandom_range(1, 6));
            for (int j = 0; j < d; j++) begin
                wr_done = spur && (j == d - 1 || $urandom_range(0, 1) == 1);
                tick();
                wr_done = 1'b0;
                check("rd_active_early", rd_active, 0);
            end
            wt_done = 1'b1;
            wr_done = spur && ($urandom_range(0, 1) == 1);
            tick();
            wt_done = 1'b0; wr_done = 1'b0;
            check("rd_active_k1", rd_active, 0);
            tick();
            check("rd_active_k2", rd_active, 1);
            d = (dr != 0) ? dr : int'($urandom_range(1, 6));
            for (int j = 0; j < d; j++) begin
                wt_done = spur && ($urandom_range(0, 1) == 1);
                tick();
                wt_done = 1'b0;
                check("wr_wait_quiet", {30'd0, wt_active, done}, 0);
            end
            if (i == n - 1) cmd_valid = 1'b0;
            wr_done = 1'b1;
            wt_done = spur && ($urandom_range(0, 1) == 1);
            tick();
            wr_done = 1'b0; wt_done = 1'b0;
            check("m1_quiet", {30'd0, wt_active, done}, 0);
            tick();
            if (i == n - 1) check("done_m2", done, 1);
        end
        tick();
        check("done_single", done, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
        check("wt_pulses", cnt_wt - w0, n);
        check("rd_pulses", cnt_rd - r0, n);
        check("done_pulses", cnt_done - d0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pulses"}, {29'd0, wt_active, rd_active, done}, 0);
        check({tag, "_wt_addr"}, wt_addr, 0);
        check({tag, "_rd_base"}, rd_base, 0);
        check({tag, "_wr_base"}, wr_base, 0);
        check({tag, "_tile_idx"}, tile_idx, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_num_tiles = '0;
        cmd_wt_base = '0; cmd_rd_base = '0; cmd_wr_base = '0;
        wt_done = 1'b0; wr_done = 1'b0;
        #12;
        check_reset_values("reset");
        tick();
        reset = 1'b0;
        tick();

        run_cmd(1, 8'h10, 8'h20, 8'h30, 5, 40, 1'b0);
        run_cmd(3, 8'h00, 8'h40, 8'h80, 0, 0, 1'b0);
        run_cmd(0, 8'h11, 8'h22, 8'h33, 0, 0, 1'b0);
        run_cmd(2, 8'h05, 8'hF8, 8'hF0, 0, 0, 1'b0);
        run_cmd(2, 8'h00, 8'h00, 8'h00, 3, 2, 1'b1);
        for (int r = 0; r < 6; r++)
            run_cmd($urandom_range(1, 4), AW'($urandom), AW'($urandom), AW'($urandom), 0, 0, 1'b1);
        run_cmd(255, AW'($urandom), AW'($urandom), AW'($urandom), 1, 1, 1'b0);

        // Reset asserted while waiting for the output write
        wait_ready();
        cmd_valid = 1'b1; cmd_num_tiles = 8'd2;
        cmd_wt_base = 8'h31; cmd_rd_base = 8'h42; cmd_wr_base = 8'h53;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        wt_done = 1'b1;
        tick();
        wt_done = 1'b0;
        tick(); tick();
        check("pre_reset_busy", busy, 1);
        check("pre_reset_rd_base", rd_base, 8'h42);
        d0 = cnt_done;
        #2 reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        tick();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        check("no_done_after_reset", cnt_done - d0, 0);
        run_cmd(2, 8'hA0, 8'hB0, 8'hC0, 0, 0, 1'b0);

`ifdef MMU_SCHED_WATCHDOG_EN
        // wt_done never arrives: watchdog ends the run 20 cycles into WAIT_W
        wait_ready();
        cmd_valid = 1'b1; cmd_num_tiles = 8'd1;
        tick();
        cmd_valid = 1'b0;
        check("wd_wt_active", wt_active, 1);
        for (int j = 0; j < 20; j++) begin
            tick();
            check("wd_wait_quiet", done, 0);
        end
        tick();
        check("wd_done", done, 1);
        check("wd_timeout", timeout, 1);
        tick();
        check("wd_timeout_sticky", timeout, 1);
        check("wd_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_num_tiles = 8'd1;
        tick();
        cmd_valid = 1'b0;
        check("wd_timeout_cleared", timeout, 0);
        tick(); tick();
        wt_done = 1'b1; tick(); wt_done = 1'b0;
        tick(); tick(); tick();
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        tick();
        check("wd_normal_done", done, 1);
        check("wd_normal_timeout", timeout, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
